// File: rtl/addsub_chk_pkg.sv
// Shared types and sizes for the adder/subtractor sweep checker.
// Used by the checker top, its reference model and benches.
package addsub_chk_pkg;

  localparam int NUM_VECTORS = 512;
  localparam int VEC_W = 9;
  localparam int OP_W = 4;
  localparam int ERR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic            cin;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } vec_t;

endpackage

// File: rtl/addsub_ref_model.sv
// Combinational golden model of the 4-bit adder/subtractor.
// Subtract is a + ~b + 1, so c0 is the no-borrow flag.
module addsub_ref_model
  import addsub_chk_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            cin,
  output logic [OP_W-1:0] s,
  output logic            c0
);

  logic [OP_W:0] sum;

  always_comb begin
    sum = {1'b0, a}
        + {1'b0, b ^ {OP_W{cin}}}
        + {{OP_W{1'b0}}, cin};
  end

  assign {c0, s} = sum;

endmodule

// File: rtl/addsub_selfcheck.sv
// Exhaustive self-check sweep driving an external 4-bit add/sub.
// Optional ADDSUB_STOP_ON_ERR_EN: halt and freeze on first mismatch.
module addsub_selfcheck
  import addsub_chk_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [OP_W-1:0]       a,
  output logic [OP_W-1:0]       b,
  output logic                  cin,
  input  logic [OP_W-1:0]       s,
  input  logic                  c0,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [VEC_W-1:0]      first_err_vec
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  state_t           state;
  state_t           state_n;
  logic [VEC_W-1:0] v;
  logic [CNT_W-1:0] cnt;
  vec_t             cur;

  logic             clr;
  logic             ld;
  logic             inc_v;
  logic             rec_err;
  logic             mismatch;

  logic [OP_W-1:0]  exp_s;
  logic             exp_c0;

  addsub_ref_model u_ref (
    .a   (a),
    .b   (b),
    .cin (cin),
    .s   (exp_s),
    .c0  (exp_c0)
  );

  assign cur = vec_t'(v);
  assign mismatch = (s != exp_s) || (c0 != exp_c0);

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    ld      = 1'b0;
    inc_v   = 1'b0;
    rec_err = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          clr     = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        ld      = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt == '0)
          state_n = CHECK;
      end
      CHECK: begin
        rec_err = mismatch;
`ifdef ADDSUB_STOP_ON_ERR_EN
        if (mismatch || v == LAST_VEC) begin
          state_n = DONE;
        end else begin
          inc_v   = 1'b1;
          state_n = LOAD;
        end
`else
        if (v == LAST_VEC) begin
          state_n = DONE;
        end else begin
          inc_v   = 1'b1;
          state_n = LOAD;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v             <= '0;
      cnt           <= '0;
      a             <= '0;
      b             <= '0;
      cin           <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
    end else begin
      if (clr) begin
        v             <= '0;
        err_count     <= '0;
        first_err_vec <= '0;
      end
      if (inc_v)
        v <= v + 1'b1;
      if (ld) begin
        a   <= cur.a;
        b   <= cur.b;
        cin <= cur.cin;
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (rec_err) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0)
          first_err_vec <= v;
      end
    end
  end

  assign busy = (state == LOAD) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule
